// File: rtl/key_pkg.sv
// Shared key-path definitions: one-hot gesture states and default timing
// derived from a single clock frequency.
package key_pkg;

  localparam int unsigned CLK_FREQ      = 50_000_000;
  localparam int unsigned KG_LONG_CNT   = CLK_FREQ;      // 1 s
  localparam int unsigned KG_GAP_CNT    = CLK_FREQ / 4;  // 250 ms
  localparam int unsigned KG_REPEAT_CNT = CLK_FREQ / 5;  // 200 ms
  localparam int unsigned KG_CNT_W      = 26;

  typedef enum logic [4:0] {
    KG_IDLE   = 5'b00001,
    KG_PRESS1 = 5'b00010,
    KG_WAIT2  = 5'b00100,
    KG_PRESS2 = 5'b01000,
    KG_HOLD   = 5'b10000
  } kg_state_e;

endpackage

// File: rtl/key_gesture_if.sv
// Key gesture bus: debounced key inputs and gesture outputs.
interface key_gesture_if;

  logic key_status;
  logic key_event;
  logic single_click;
  logic double_click;
  logic long_press;
  logic key_repeat;
  logic key_held;

  modport master (
    output key_status, key_event,
    input  single_click, double_click, long_press, key_repeat, key_held
  );

  modport slave (
    input  key_status, key_event,
    output single_click, double_click, long_press, key_repeat, key_held
  );

endinterface

// File: rtl/key_gesture_timer.sv
// Gesture interval timer: clearable, enabled up-counter with a terminal
// compare against a limit chosen by the FSM each cycle.
module key_gesture_timer
  import key_pkg::*;
#(
  parameter int unsigned CNT_W = KG_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             done_c
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign done_c = (cnt == limit);

endmodule

// File: rtl/key_gesture.sv
// Classifies debounced key press/release sequences into single-click,
// double-click, long-press and auto-repeat pulses.
module key_gesture
  import key_pkg::*;
#(
  parameter int unsigned LONG_CNT   = KG_LONG_CNT,
  parameter int unsigned GAP_CNT    = KG_GAP_CNT,
  parameter int unsigned REPEAT_CNT = KG_REPEAT_CNT,
  parameter int unsigned CNT_W      = KG_CNT_W
) (
  input logic          clk,
  input logic          rst_n,
  key_gesture_if.slave bus
);

  kg_state_e        state;
  kg_state_e        state_next;
  logic             press_ev;
  logic             release_ev;
  logic             tmr_clr;
  logic             tmr_en;
  logic             tmr_rep_clr;
  logic [CNT_W-1:0] tmr_limit;
  logic             tmr_done_c;
  logic             single_nxt;
  logic             double_nxt;
  logic             long_nxt;
  logic             repeat_nxt;
  logic             held_nxt;

  assign press_ev   = bus.key_event && !bus.key_status;
  assign release_ev = bus.key_event &&  bus.key_status;

  key_gesture_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .limit  (tmr_limit),
    .done_c (tmr_done_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= KG_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Key events always take priority over a timer expiry in the same cycle.
  always_comb begin
    state_next  = state;
    tmr_en      = 1'b0;
    tmr_rep_clr = 1'b0;
    tmr_limit   = '0;
    single_nxt  = 1'b0;
    double_nxt  = 1'b0;
    long_nxt    = 1'b0;
    repeat_nxt  = 1'b0;
    case (state)
      KG_IDLE: begin
        if (press_ev) state_next = KG_PRESS1;
      end
      KG_PRESS1: begin
        tmr_en    = 1'b1;
        tmr_limit = CNT_W'(LONG_CNT - 1);
        if (release_ev) begin
          state_next = KG_WAIT2;
        end else if (tmr_done_c) begin
          state_next = KG_HOLD;
          long_nxt   = 1'b1;
        end
      end
      KG_WAIT2: begin
        tmr_en    = 1'b1;
        tmr_limit = CNT_W'(GAP_CNT - 1);
        if (press_ev) begin
          state_next = KG_PRESS2;
        end else if (tmr_done_c) begin
          state_next = KG_IDLE;
          single_nxt = 1'b1;
        end
      end
      KG_PRESS2: begin
        if (release_ev) begin
          state_next = KG_IDLE;
          double_nxt = 1'b1;
        end
      end
      KG_HOLD: begin
        tmr_en    = 1'b1;
        tmr_limit = CNT_W'(REPEAT_CNT - 1);
        if (release_ev) begin
          state_next = KG_IDLE;
        end else if (tmr_done_c) begin
          repeat_nxt  = 1'b1;
          tmr_rep_clr = 1'b1;
        end
      end
      default: state_next = KG_IDLE;
    endcase
    held_nxt = (state_next == KG_HOLD);
    tmr_clr  = tmr_rep_clr || (state_next != state);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.single_click <= 1'b0;
      bus.double_click <= 1'b0;
      bus.long_press   <= 1'b0;
      bus.key_repeat   <= 1'b0;
      bus.key_held     <= 1'b0;
    end else begin
      bus.single_click <= single_nxt;
      bus.double_click <= double_nxt;
      bus.long_press   <= long_nxt;
      bus.key_repeat   <= repeat_nxt;
      bus.key_held     <= held_nxt;
    end
  end

endmodule
